pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard, redirect and trap sequencing controller.
// Ports:
//   clk, rst         clock, sync active-high reset
//   jump_flag_i/addr EX-stage taken branch/jump and target
//   load_use_i       ID-stage load-use hazard
//   mdu_busy_i       multi-cycle mul/div busy in EX
//   mem_busy_i       data memory wait
//   irq_i, ecall_i   trap requests
//   mret_i           trap return request
//   ex_pc_i          PC of the EX-stage instruction
//   mtvec_i, mepc_i  CSR trap vector / return PC
//   stall_*_o        hold PC / IF-ID / ID-EX / EX-MEM
//   flush_*_o        load NOP into IF-ID / ID-EX / EX-MEM
//   redirect_o/addr  PC override
//   trap_o, trap_cause_o, trap_epc_o, mret_o  CSR update strobes
//   stall_cnt_o      saturating count of stall_if_o cycles
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [63:0] jump_addr_i,
    input  logic        load_use_i,
    input  logic        mdu_busy_i,
    input  logic        mem_busy_i,
    input  logic        irq_i,
    input  logic        ecall_i,
    input  logic        mret_i,
    input  logic [63:0] ex_pc_i,
    input  logic [63:0] mtvec_i,
    input  logic [63:0] mepc_i,
    output logic        stall_if_o,
    output logic        stall_id_o,
    output logic        stall_ex_o,
    output logic        stall_mem_o,
    output logic        flush_id_o,
    output logic        flush_ex_o,
    output logic        flush_mem_o,
    output logic        redirect_o,
    output logic [63:0] redirect_addr_o,
    output logic        trap_o,
    output logic [63:0] trap_cause_o,
    output logic [63:0] trap_epc_o,
    output logic        mret_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        TRAP,
        RET
    } state_t;

    localparam logic [63:0] CAUSE_IRQ   = 64'h8000_0000_0000_0007;
    localparam logic [63:0] CAUSE_ECALL = 64'd11;

    state_t      state_q;
    logic [63:0] epc_q;
    logic [63:0] cause_q;
    logic [31:0] stall_cnt_q;

    logic trap_req;
    logic leave_run;

    assign trap_req  = irq_i | ecall_i;
    assign leave_run = trap_req | mret_i;

    always_comb begin
        stall_if_o      = 1'b0;
        stall_id_o      = 1'b0;
        stall_ex_o      = 1'b0;
        stall_mem_o     = 1'b0;
        flush_id_o      = 1'b0;
        flush_ex_o      = 1'b0;
        flush_mem_o     = 1'b0;
        redirect_o      = 1'b0;
        redirect_addr_o = 64'd0;
        trap_o          = 1'b0;
        trap_cause_o    = 64'd0;
        trap_epc_o      = 64'd0;
        mret_o          = 1'b0;
        stall_cnt_o     = 32'd0;
        if (!rst) begin
            stall_cnt_o = stall_cnt_q;
            unique case (state_q)
                RUN: begin
                    // The leaving cycle freezes the front end and
                    // bubbles MEM; jumps and load-use are dropped.
                    if (leave_run) begin
                        stall_if_o  = 1'b1;
                        stall_id_o  = 1'b1;
                        stall_ex_o  = 1'b1;
                        flush_mem_o = 1'b1;
                    end else if (mem_busy_i) begin
                        stall_if_o  = 1'b1;
                        stall_id_o  = 1'b1;
                        stall_ex_o  = 1'b1;
                        stall_mem_o = 1'b1;
                    end else if (mdu_busy_i) begin
                        stall_if_o  = 1'b1;
                        stall_id_o  = 1'b1;
                        stall_ex_o  = 1'b1;
                        flush_mem_o = 1'b1;
                    end else if (jump_flag_i) begin
                        redirect_o      = 1'b1;
                        redirect_addr_o = jump_addr_i;
                        flush_id_o      = 1'b1;
                        flush_ex_o      = 1'b1;
                    end else if (load_use_i) begin
                        stall_if_o = 1'b1;
                        stall_id_o = 1'b1;
                        flush_ex_o = 1'b1;
                    end
                end
                DRAIN: begin
                    stall_if_o  = 1'b1;
                    stall_id_o  = 1'b1;
                    stall_ex_o  = 1'b1;
                    stall_mem_o = mem_busy_i;
                    flush_mem_o = !mem_busy_i;
                end
                TRAP: begin
                    trap_o          = 1'b1;
                    trap_cause_o    = cause_q;
                    trap_epc_o      = epc_q;
                    redirect_o      = 1'b1;
                    redirect_addr_o = mtvec_i;
                    flush_id_o      = 1'b1;
                    flush_ex_o      = 1'b1;
                    flush_mem_o     = 1'b1;
                end
                RET: begin
                    mret_o          = 1'b1;
                    redirect_o      = 1'b1;
                    redirect_addr_o = mepc_i;
                    flush_id_o      = 1'b1;
                    flush_ex_o      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            epc_q       <= 64'd0;
            cause_q     <= 64'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (stall_if_o && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            unique case (state_q)
                RUN: begin
                    if (trap_req) begin
                        epc_q   <= ex_pc_i;
                        cause_q <= irq_i ? CAUSE_IRQ
                                         : CAUSE_ECALL;
                        state_q <= mem_busy_i ? DRAIN : TRAP;
                    end else if (mret_i) begin
                        state_q <= RET;
                    end
                end
                DRAIN: begin
                    if (!mem_busy_i)
                        state_q <= TRAP;
                end
                TRAP:    state_q <= RUN;
                RET:     state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
// Control outputs are packed into one vector for compact checks.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        jump_flag_i;
    logic [63:0] jump_addr_i;
    logic        load_use_i;
    logic        mdu_busy_i;
    logic        mem_busy_i;
    logic        irq_i;
    logic        ecall_i;
    logic        mret_i;
    logic [63:0] ex_pc_i;
    logic [63:0] mtvec_i;
    logic [63:0] mepc_i;
    logic        stall_if_o;
    logic        stall_id_o;
    logic        stall_ex_o;
    logic        stall_mem_o;
    logic        flush_id_o;
    logic        flush_ex_o;
    logic        flush_mem_o;
    logic        redirect_o;
    logic [63:0] redirect_addr_o;
    logic        trap_o;
    logic [63:0] trap_cause_o;
    logic [63:0] trap_epc_o;
    logic        mret_o;
    logic [31:0] stall_cnt_o;

    pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .jump_flag_i    (jump_flag_i),
        .jump_addr_i    (jump_addr_i),
        .load_use_i     (load_use_i),
        .mdu_busy_i     (mdu_busy_i),
        .mem_busy_i     (mem_busy_i),
        .irq_i          (irq_i),
        .ecall_i        (ecall_i),
        .mret_i         (mret_i),
        .ex_pc_i        (ex_pc_i),
        .mtvec_i        (mtvec_i),
        .mepc_i         (mepc_i),
        .stall_if_o     (stall_if_o),
        .stall_id_o     (stall_id_o),
        .stall_ex_o     (stall_ex_o),
        .stall_mem_o    (stall_mem_o),
        .flush_id_o     (flush_id_o),
        .flush_ex_o     (flush_ex_o),
        .flush_mem_o    (flush_mem_o),
        .redirect_o     (redirect_o),
        .redirect_addr_o(redirect_addr_o),
        .trap_o         (trap_o),
        .trap_cause_o   (trap_cause_o),
        .trap_epc_o     (trap_epc_o),
        .mret_o         (mret_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    localparam logic [9:0] S_IF  = 10'b10_0000_0000;
    localparam logic [9:0] S_ID  = 10'b01_0000_0000;
    localparam logic [9:0] S_EX  = 10'b00_1000_0000;
    localparam logic [9:0] S_MEM = 10'b00_0100_0000;
    localparam logic [9:0] F_ID  = 10'b00_0010_0000;
    localparam logic [9:0] F_EX  = 10'b00_0001_0000;
    localparam logic [9:0] F_MEM = 10'b00_0000_1000;
    localparam logic [9:0] RDIR  = 10'b00_0000_0100;
    localparam logic [9:0] TRAP  = 10'b00_0000_0010;
    localparam logic [9:0] MRET  = 10'b00_0000_0001;
    localparam logic [9:0] S3    = S_IF | S_ID | S_EX;
    localparam logic [9:0] NONE  = 10'd0;

    logic [9:0] ctl;
    assign ctl = {stall_if_o, stall_id_o, stall_ex_o,
                  stall_mem_o, flush_id_o, flush_ex_o,
                  flush_mem_o, redirect_o, trap_o, mret_o};

    int n_chk;
    int n_fail;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        jump_flag_i = 1'b1;
        jump_addr_i = 64'h8000_0040;
        load_use_i  = 1'b1;
        mdu_busy_i  = 1'b0;
        mem_busy_i  = 1'b1;
        irq_i       = 1'b1;
        ecall_i     = 1'b0;
        mret_i      = 1'b0;
        ex_pc_i     = 64'h8000_0100;
        mtvec_i     = 64'h8000_1000;
        mepc_i      = 64'h8000_0100;

        cyc();
        cyc();
        settle();
        check("rst_ctl", 64'(ctl), 64'(NONE));
        check("rst_addr", redirect_addr_o, 64'd0);
        check("rst_cnt", 64'(stall_cnt_o), 64'd0);
        check("rst_cause", trap_cause_o, 64'd0);

        // first cycle out of reset: jump taken
        irq_i      = 1'b0;
        mem_busy_i = 1'b0;
        load_use_i = 1'b0;
        rst        = 1'b0;
        settle();
        check("jmp_ctl", 64'(ctl), 64'(RDIR | F_ID | F_EX));
        check("jmp_addr", redirect_addr_o, 64'h8000_0040);
        cyc();
        jump_flag_i = 1'b0;
        settle();
        check("jmp_cnt", 64'(stall_cnt_o), 64'd0);
        check("idle_addr", redirect_addr_o, 64'd0);

        // load-use
        load_use_i = 1'b1;
        settle();
        check("lu_ctl", 64'(ctl), 64'(S_IF | S_ID | F_EX));
        cyc();
        load_use_i = 1'b0;
        settle();
        check("lu_cnt", 64'(stall_cnt_o), 64'd1);
        check("idle_ctl", 64'(ctl), 64'(NONE));

        // mdu busy masks a pending jump
        jump_flag_i = 1'b1;
        jump_addr_i = 64'h8000_0080;
        mdu_busy_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("mdu_ctl", 64'(ctl), 64'(S3 | F_MEM));
            check("mdu_addr", redirect_addr_o, 64'd0);
            cyc();
        end
        mdu_busy_i = 1'b0;
        settle();
        check("mdu_jmp", 64'(ctl), 64'(RDIR | F_ID | F_EX));
        check("mdu_jaddr", redirect_addr_o, 64'h8000_0080);
        check("mdu_cnt", 64'(stall_cnt_o), 64'd4);

        // mem busy outranks mdu and jump
        mdu_busy_i = 1'b1;
        mem_busy_i = 1'b1;
        settle();
        check("mem_ctl", 64'(ctl), 64'(S3 | S_MEM));
        cyc();
        jump_flag_i = 1'b0;
        mdu_busy_i  = 1'b0;
        settle();
        check("mem_cnt", 64'(stall_cnt_o), 64'd5);

        // ecall with memory busy: RUN -> DRAIN x2 -> TRAP
        ecall_i    = 1'b1;
        jump_flag_i = 1'b1;
        ex_pc_i    = 64'h8000_0100;
        settle();
        check("ec_run", 64'(ctl), 64'(S3 | F_MEM));
        check("ec_rdir", 64'(redirect_o), 64'd0);
        cyc();
        ecall_i     = 1'b0;
        jump_flag_i = 1'b0;
        ex_pc_i     = 64'h0;
        settle();
        check("drain1", 64'(ctl), 64'(S3 | S_MEM));
        cyc();
        mem_busy_i = 1'b0;
        settle();
        check("drain2", 64'(ctl), 64'(S3 | F_MEM));
        cyc();
        settle();
        check("ec_trap",
              64'(ctl), 64'(TRAP | RDIR | F_ID | F_EX | F_MEM));
        check("ec_cause", trap_cause_o, 64'd11);
        check("ec_epc", trap_epc_o, 64'h8000_0100);
        check("ec_vec", redirect_addr_o, 64'h8000_1000);
        check("ec_cnt", 64'(stall_cnt_o), 64'd8);
        cyc();
        settle();
        check("ec_back", 64'(ctl), 64'(NONE));
        check("ec_cz", trap_cause_o, 64'd0);
        check("ec_ez", trap_epc_o, 64'd0);

        // irq and ecall together, no memory wait
        irq_i   = 1'b1;
        ecall_i = 1'b1;
        ex_pc_i = 64'h8000_0200;
        settle();
        check("irq_run", 64'(ctl), 64'(S3 | F_MEM));
        cyc();
        irq_i   = 1'b0;
        ecall_i = 1'b0;
        settle();
        check("irq_trap",
              64'(ctl), 64'(TRAP | RDIR | F_ID | F_EX | F_MEM));
        check("irq_cause", trap_cause_o,
              64'h8000_0000_0000_0007);
        check("irq_epc", trap_epc_o, 64'h8000_0200);
        cyc();
        settle();
        check("irq_back", 64'(ctl), 64'(NONE));

        // mret
        mret_i = 1'b1;
        mepc_i = 64'h8000_0100;
        settle();
        check("mr_run", 64'(ctl), 64'(S3 | F_MEM));
        cyc();
        mret_i = 1'b0;
        settle();
        check("mr_ret", 64'(ctl), 64'(MRET | RDIR | F_ID | F_EX));
        check("mr_addr", redirect_addr_o, 64'h8000_0100);
        check("mr_cause", trap_cause_o, 64'd0);
        cyc();
        settle();
        check("mr_back", 64'(ctl), 64'(NONE));

        // reset in the middle of DRAIN
        ecall_i    = 1'b1;
        mem_busy_i = 1'b1;
        cyc();
        ecall_i = 1'b0;
        settle();
        check("rd_drain", 64'(ctl), 64'(S3 | S_MEM));
        rst = 1'b1;
        settle();
        check("rd_ctl", 64'(ctl), 64'(NONE));
        check("rd_cnto", 64'(stall_cnt_o), 64'd0);
        cyc();
        rst        = 1'b0;
        mem_busy_i = 1'b0;
        settle();
        check("rd_run", 64'(ctl), 64'(NONE));
        check("rd_cnt", 64'(stall_cnt_o), 64'd0);
        cyc();
        settle();
        check("rd_notrap", 64'(ctl), 64'(NONE));

        // saturation: preload near the top, then stall
        dut.stall_cnt_q = 32'hFFFF_FFFE;
        mem_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            settle();
            check("sat_cnt", 64'(stall_cnt_o),
                  64'h0000_0000_FFFF_FFFF);
        end
        mem_busy_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
